menu_navigator: RTL and testbench
=================================

# menu_navigator

Input front-end for the menu screens. Synchronises and debounces the four raw push-buttons and generates auto-repeat for up/down. It produces the `navigation.selected_element` index that the VGA game renderer uses to highlight a row. Index changes are applied only at the start of vertical sync, so a highlighted row never changes mid-frame. Select/back are emitted as one-cycle pulses for the game-state controller.

## Interface
- `NUM_ELEMENTS`, 3: number of selectable rows (2..16); index range 0..NUM_ELEMENTS-1.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change (10 ms @ 25 MHz).
- `REPEAT_DELAY`, 12500000: cycles a held up/down key is kept before the first auto-repeat.
- `REPEAT_PERIOD`, 2500000: cycles between subsequent auto-repeats.
- `clk` in 1: pixel clock, the same clock as the renderer.
- `reset` in 1: synchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_select`, `btn_back` in 1 each: raw asynchronous buttons, active-high.
- `vsync` in 1: renderer VSYNC, same clock domain, active-high.
- `selected_element` out 4: current highlighted row.
- `element_changed` out 1: one-cycle pulse, high in the cycle `selected_element` takes a new value.
- `select_pulse` out 1: one-cycle pulse per accepted select press.
- `back_pulse` out 1: one-cycle pulse per accepted back press.

## Operation
- Sync: each button passes through a 2-FF synchroniser. Both FFs reset to 0.
- Debounce, per button:
  - Registers: stable level (reset 0) and counter (reset 0, width clog2(DEBOUNCE_CYCLES+1)).
  - Counter clears whenever the synced input equals the stable level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves the stable level unchanged.
- Press event: a rising edge of the stable level, registered, lasting one cycle.
- Auto-repeat (up/down only):
  - A repeat counter starts at the press event.
  - While the key stays stable-high, extra events are generated at REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - Releasing the key (stable level goes low) clears the counter.
- Direction conflict: up and down events in the same cycle are both discarded.
- Pending move register {valid, dir}, reset invalid:
  - An up/down event loads it, overwriting any older pending move (the newest wins).
- Frame apply at a `vsync` rising edge (vsync high and previous sample low; the previous-sample register resets to 0):
  - If a move is pending, `selected_element` updates and `element_changed` is 1 for that cycle. Pending then clears.
  - down: index NUM_ELEMENTS-1 wraps to 0, else +1.
  - up: index 0 wraps to NUM_ELEMENTS-1, else -1.
  - An event in the same cycle as the vsync edge does not join this apply. The old pending move is applied, and the new event becomes pending for the next frame.
  - With nothing pending, the edge has no effect.
- select/back:
  - The press event drives the pulse directly. These pulses are not frame-synchronised and do not auto-repeat.
  - Same-cycle select and back events: `back_pulse` is asserted and select is dropped.
- Reset mid-operation clears everything, including debounced levels, pending moves and repeat timers. A button already held when reset falls must be re-accepted through the full debounce.

## Timing
- Reset values: `selected_element`=0; `element_changed`, `select_pulse` and `back_pulse` all 0.
- All outputs are registered.
- Latency: raw input first sampled high at cycle 0, held stable → press pulse at cycle DEBOUNCE_CYCLES+3.
- Release latency: DEBOUNCE_CYCLES+2 cycles until the stable level goes low. No pulse is generated on release.
- Index update: exactly 1 cycle after the clock edge where vsync is first sampled high.
- Max rate: one index step per frame. Extra moves within one frame collapse to the newest.

## Test plan
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, NUM_ELEMENTS=3.
- Debounce:
  - `btn_select` high for 3 cycles, then low → no `select_pulse`.
  - Held 10 cycles → exactly one `select_pulse`, at cycle 7 after first sample.
- Wrap:
  - From reset, press up once, then one vsync rising edge → `selected_element`=2 and `element_changed` for 1 cycle.
  - Then press down twice, each followed by a vsync edge → 0, then 1.
- Frame gating:
  - Press down with no vsync edge for 100 cycles → index stays 0.
  - First vsync edge → 1.
  - Vsync held high, or a second edge with nothing pending → no change.
- Auto-repeat:
  - Hold down for 40 cycles after acceptance → events at 0, 20 and 28 cycles after the press pulse.
  - With a vsync edge between each event → index sequence 1, 2, 0.
- Conflicts:
  - up and down accepted in the same cycle → no pending move; index unchanged after vsync.
  - select and back in the same cycle → `back_pulse` only.
- Reset mid-operation:
  - Assert `reset` with a move pending and `btn_down` held → all outputs 0.
  - After release, with `btn_down` still held → a new press is accepted at cycle 7 after reset falls, and the index becomes 1 only at the next vsync edge.

Source files
------------

// File: rtl/menu_navigator_if.sv
`default_nettype none
// ============================================================================
//  Module      : menu_navigator_if
//  Description : Bundle of the menu front-end signals. It carries the raw
//                buttons and the renderer vsync into the navigator, and the
//                highlight index and the event pulses out of it.
//                master : drives buttons/vsync, observes results (board/bench)
//                slave  : the navigator itself
//  Signals     : btn_up, btn_down, btn_select, btn_back : raw buttons, active-high
//                vsync            : renderer VSYNC, pixel-clock domain
//                selected_element : highlighted row index (4 bits)
//                element_changed  : 1-cycle pulse when the index takes a new value
//                select_pulse     : 1-cycle pulse per accepted select press
//                back_pulse       : 1-cycle pulse per accepted back press
//  Revision    : 1.0 - initial release
// ============================================================================
interface menu_navigator_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_select;
  logic       btn_back;
  logic       vsync;
  logic [3:0] selected_element;
  logic       element_changed;
  logic       select_pulse;
  logic       back_pulse;

  modport master (
    output btn_up, btn_down, btn_select, btn_back, vsync,
    input  selected_element, element_changed, select_pulse, back_pulse
  );

  modport slave (
    input  btn_up, btn_down, btn_select, btn_back, vsync,
    output selected_element, element_changed, select_pulse, back_pulse
  );
endinterface
`default_nettype wire

// File: rtl/menu_navigator.sv
`default_nettype none
// ============================================================================
//  Module      : menu_navigator
//  Description : Menu input front-end. Synchronises and debounces four push
//                buttons, adds auto-repeat to up/down, and steps the
//                highlighted row only at a vsync rising edge, so the rendered
//                highlight never changes mid-frame. Select/back leave as
//                immediate one-cycle pulses.
//  Ports       : clk        - pixel clock (shared with the renderer)
//                reset      - synchronous, active-high
//                navigation - menu_navigator_if.slave (buttons, vsync in;
//                             selected_element, element_changed,
//                             select_pulse, back_pulse out)
//  Revision    : 1.0 - initial release
// ============================================================================
module menu_navigator #(
  parameter int NUM_ELEMENTS    = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  menu_navigator_if.slave navigation
);

  localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam int              RP_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  // After a repeat fires, the counter is rewound so it hits RP_DELAY again
  // exactly REPEAT_PERIOD cycles later; one comparator serves both intervals.
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  localparam logic [3:0]      LAST_IDX  = 4'(NUM_ELEMENTS - 1);

  // Button order: 0 up, 1 down, 2 select, 3 back
  logic [3:0] btn_raw;
  logic [3:0] press;   // registered rising edge of each debounced level
  logic [1:0] held;    // debounced level of up/down, gates auto-repeat
  logic [1:0] move_evt;

  assign btn_raw = {navigation.btn_back, navigation.btn_select,
                    navigation.btn_down, navigation.btn_up};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and press detector
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The flip is taken on the cycle after the counter has reached
    // DEBOUNCE_CYCLES, whatever the input is doing at that moment.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (cnt_q == DB_MAX) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
      end else if (sync2_q == stable_q) begin
        cnt_d    = '0;
      end else begin
        cnt_d    = cnt_q + 1'b1;
      end
      press_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
        press_q  <= 1'b0;
      end else begin
        sync1_q  <= btn_raw[gi];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        press_q  <= press_d;
      end
    end

    assign press[gi] = press_q;

    if (gi < 2) begin : g_held
      assign held[gi] = stable_q;
    end
  end

  // --------------------------------------------------------------------------
  // Auto-repeat for up/down. rep_q counts cycles since the press (0 = idle).
  // --------------------------------------------------------------------------
  for (genvar gr = 0; gr < 2; gr++) begin : g_rep
    logic [RP_W-1:0] rep_q, rep_d;
    logic            rep_hit;

    always_comb begin
      rep_hit = held[gr] && (rep_q == RP_DELAY);
      rep_d   = rep_q;
      if (!held[gr]) begin
        rep_d = '0;
      end else if (press[gr]) begin
        rep_d = RP_W'(1);
      end else if (rep_hit) begin
        rep_d = RP_RELOAD;
      end else if (rep_q != '0) begin
        rep_d = rep_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end

    assign move_evt[gr] = press[gr] | rep_hit;
  end

  // Simultaneous up and down cancel each other.
  logic up_evt, dn_evt;
  assign up_evt = move_evt[0] & ~move_evt[1];
  assign dn_evt = move_evt[1] & ~move_evt[0];

  // --------------------------------------------------------------------------
  // Frame-synchronous index update
  // --------------------------------------------------------------------------
  logic       vsync_q, vsync_prev_q;
  logic       frame_rise;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_dir_q, pend_dir_d;      // 1 = down, 0 = up
  logic [3:0] sel_q, sel_d;
  logic       changed_q, changed_d;
  logic       select_pulse_q, select_pulse_d;
  logic       back_pulse_q, back_pulse_d;

  assign frame_rise = vsync_q & ~vsync_prev_q;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    sel_d        = sel_q;
    changed_d    = 1'b0;

    if (frame_rise) begin
      if (pend_valid_q) begin
        changed_d = 1'b1;
        if (pend_dir_q) begin
          sel_d = (sel_q == LAST_IDX) ? 4'd0 : sel_q + 4'd1;
        end else begin
          sel_d = (sel_q == 4'd0) ? LAST_IDX : sel_q - 4'd1;
        end
      end
      pend_valid_d = 1'b0;
    end

    // Loaded after the apply above, so an event coinciding with the frame
    // edge waits for the next frame and the newest move always wins.
    if (up_evt || dn_evt) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = dn_evt;
    end

    // Back has priority over select when both are pressed together.
    select_pulse_d = press[2] & ~press[3];
    back_pulse_d   = press[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q        <= 1'b0;
      vsync_prev_q   <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_dir_q     <= 1'b0;
      sel_q          <= 4'd0;
      changed_q      <= 1'b0;
      select_pulse_q <= 1'b0;
      back_pulse_q   <= 1'b0;
    end else begin
      vsync_q        <= navigation.vsync;
      vsync_prev_q   <= vsync_q;
      pend_valid_q   <= pend_valid_d;
      pend_dir_q     <= pend_dir_d;
      sel_q          <= sel_d;
      changed_q      <= changed_d;
      select_pulse_q <= select_pulse_d;
      back_pulse_q   <= back_pulse_d;
    end
  end

  assign navigation.selected_element = sel_q;
  assign navigation.element_changed  = changed_q;
  assign navigation.select_pulse     = select_pulse_q;
  assign navigation.back_pulse       = back_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_menu_navigator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_menu_navigator
//  Description : Directed self-checking bench for menu_navigator with small
//                timing parameters (debounce 4, repeat 20/8, 3 rows).
//                Cycle c below is the clock edge numbered from the first edge
//                that samples the new button pattern; outputs are read 1 ns
//                after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_navigator;

  localparam int NUM_ELEMENTS    = 3;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_DELAY    = 20;
  localparam int REPEAT_PERIOD   = 8;

  localparam logic [3:0] B_UP   = 4'b0001;
  localparam logic [3:0] B_DOWN = 4'b0010;
  localparam logic [3:0] B_SEL  = 4'b0100;
  localparam logic [3:0] B_BACK = 4'b1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  menu_navigator_if nav ();

  menu_navigator #(
    .NUM_ELEMENTS   (NUM_ELEMENTS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .navigation(nav)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observations collected by run()
  int         n_sel, n_back, n_chg;
  int         first_sel, first_back, first_chg;
  int         chg_cyc [8];
  logic [3:0] chg_idx [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btns(input logic [3:0] p);
    nav.btn_up     = p[0];
    nav.btn_down   = p[1];
    nav.btn_select = p[2];
    nav.btn_back   = p[3];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nav.vsync = 1'b0;
    set_btns(4'b0000);
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Apply pattern for 'hold' edges (0..hold-1), drive vsync per vs_mask bit,
  // and record every output pulse over 'window' edges.
  task automatic run(input logic [3:0] pat, input int hold, input int window,
                     input logic [127:0] vs_mask);
    n_sel = 0; n_back = 0; n_chg = 0;
    first_sel = -1; first_back = -1; first_chg = -1;
    set_btns(pat);
    for (int c = 0; c < window; c++) begin
      nav.vsync = (c < 128) ? vs_mask[c] : 1'b0;
      tick();
      if (c == hold - 1) set_btns(4'b0000);
      if (nav.select_pulse) begin
        if (first_sel < 0) first_sel = c;
        n_sel++;
      end
      if (nav.back_pulse) begin
        if (first_back < 0) first_back = c;
        n_back++;
      end
      if (nav.element_changed) begin
        if (first_chg < 0) first_chg = c;
        if (n_chg < 8) begin
          chg_cyc[n_chg] = c;
          chg_idx[n_chg] = nav.selected_element;
        end
        n_chg++;
      end
    end
    nav.vsync = 1'b0;
  endtask

  // One-cycle vsync pulse: sampled at edge E, applied at edge E+1.
  task automatic frame(input string tag, input logic exp_chg, input logic [3:0] exp_idx);
    nav.vsync = 1'b1;
    tick();
    nav.vsync = 1'b0;
    tick();
    check({tag, ".changed"}, 32'(nav.element_changed), 32'(exp_chg));
    check({tag, ".index"}, 32'(nav.selected_element), 32'(exp_idx));
    tick();
    check({tag, ".changed_off"}, 32'(nav.element_changed), 32'd0);
  endtask

  logic [127:0] m;
  int           n_hi_chg;

  initial begin
    set_btns(4'b0000);
    nav.vsync = 1'b0;

    // ---- Reset state ----
    repeat (3) tick();
    check("rst.index",   32'(nav.selected_element), 32'd0);
    check("rst.changed", 32'(nav.element_changed),  32'd0);
    check("rst.select",  32'(nav.select_pulse),     32'd0);
    check("rst.back",    32'(nav.back_pulse),       32'd0);
    reset = 1'b0;
    tick();

    // ---- Debounce: 3-cycle glitch is rejected ----
    run(B_SEL, 3, 20, '0);
    check("glitch.n_select", 32'(n_sel), 32'd0);

    // ---- Debounce: 10-cycle press gives one pulse at cycle 7 ----
    run(B_SEL, 10, 25, '0);
    check("held.n_select",   32'(n_sel),     32'd1);
    check("held.first_sel",  32'(first_sel), 32'd7);
    check("held.n_back",     32'(n_back),    32'd0);

    // ---- Wrap ----
    do_reset();
    run(B_UP, 8, 20, '0);
    frame("wrap_up", 1'b1, 4'd2);
    run(B_DOWN, 8, 20, '0);
    frame("wrap_dn1", 1'b1, 4'd0);
    run(B_DOWN, 8, 20, '0);
    frame("wrap_dn2", 1'b1, 4'd1);

    // ---- Frame gating ----
    do_reset();
    run(B_DOWN, 8, 100, '0);
    check("gate.no_change", 32'(n_chg), 32'd0);
    check("gate.index",     32'(nav.selected_element), 32'd0);
    frame("gate_first", 1'b1, 4'd1);
    nav.vsync = 1'b1;
    n_hi_chg = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (nav.element_changed) n_hi_chg++;
    end
    nav.vsync = 1'b0;
    tick();
    check("gate.vsync_high_chg", 32'(n_hi_chg), 32'd0);
    check("gate.vsync_high_idx", 32'(nav.selected_element), 32'd1);
    frame("gate_nopend", 1'b0, 4'd1);

    // ---- Auto-repeat: events at cycles 6, 26, 34 (press+0/+20/+28) ----
    // vsync sampled at 14/30/38 applies at 15/31/39; the one at 50 finds
    // nothing pending because the key is released before the next repeat.
    do_reset();
    m = '0;
    m[14] = 1'b1; m[30] = 1'b1; m[38] = 1'b1; m[50] = 1'b1;
    run(B_DOWN, 32, 60, m);
    check("rep.n_changes", 32'(n_chg), 32'd3);
    check("rep.cyc0", 32'(chg_cyc[0]), 32'd15);
    check("rep.idx0", 32'(chg_idx[0]), 32'd1);
    check("rep.cyc1", 32'(chg_cyc[1]), 32'd31);
    check("rep.idx1", 32'(chg_idx[1]), 32'd2);
    check("rep.cyc2", 32'(chg_cyc[2]), 32'd39);
    check("rep.idx2", 32'(chg_idx[2]), 32'd0);

    // ---- Conflicts ----
    do_reset();
    run(B_UP | B_DOWN, 8, 20, '0);
    frame("conf_updn", 1'b0, 4'd0);
    run(B_SEL | B_BACK, 8, 20, '0);
    check("conf.n_back",     32'(n_back),     32'd1);
    check("conf.first_back", 32'(first_back), 32'd7);
    check("conf.n_select",   32'(n_sel),      32'd0);

    // ---- Reset mid-operation ----
    do_reset();
    run(B_DOWN, 8, 20, '0);
    frame("mid_pre", 1'b1, 4'd1);
    set_btns(B_DOWN);
    repeat (20) tick();              // down accepted, move pending
    reset = 1'b1;
    repeat (3) tick();
    check("mid.rst_index",   32'(nav.selected_element), 32'd0);
    check("mid.rst_changed", 32'(nav.element_changed),  32'd0);
    check("mid.rst_select",  32'(nav.select_pulse),     32'd0);
    check("mid.rst_back",    32'(nav.back_pulse),       32'd0);
    reset = 1'b0;
    // Press re-accepted at cycle 6, pending from edge 7: the frame applied at
    // edge 6 finds nothing, the one applied at edge 8 steps to 1.
    m = '0;
    m[5] = 1'b1; m[7] = 1'b1;
    run(B_DOWN, 1000, 14, m);
    check("mid.n_changes", 32'(n_chg),     32'd1);
    check("mid.chg_cycle", 32'(first_chg), 32'd8);
    check("mid.index",     32'(nav.selected_element), 32'd1);
    set_btns(4'b0000);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
